// File: rtl/eval_sequencer_pkg.sv
// Shared evaluator definitions: operator codes and sequencer state encodings.
package eval_sequencer_pkg;

  localparam int CO_W = 4;

  localparam logic [CO_W-1:0] CO_AD = 4'h1;
  localparam logic [CO_W-1:0] CO_SB = 4'h2;
  localparam logic [CO_W-1:0] CO_MU = 4'h3;
  localparam logic [CO_W-1:0] CO_DI = 4'h4;

  typedef enum logic [3:0] {
    ES_IDLE   = 4'd0,
    ES_POP_OP = 4'd1,
    ES_POP_B  = 4'd2,
    ES_POP_A  = 4'd3,
    ES_EXEC   = 4'd4,
    ES_WAIT   = 4'd5,
    ES_PUSH   = 4'd6,
    ES_DONE   = 4'd7,
    ES_ERR    = 4'd8
  } es_state_e;

endpackage

// File: rtl/eval_sequencer_ovf_detect.sv
// Signed add/sub overflow detector for the evaluator result.
// Only present when EVAL_OVF_CHECK_EN is defined.
`ifdef EVAL_OVF_CHECK_EN
module eval_ovf_detect
  import eval_sequencer_pkg::*;
#(
  parameter int CD_N = 16,
  parameter int CO_N = 4
) (
  input  logic signed [CD_N-1:0] A,
  input  logic signed [CD_N-1:0] B,
  input  logic signed [CD_N-1:0] C,
  input  logic        [CO_N-1:0] op,
  output logic                   ovf
);

  logic sa, sb, sc;

  assign sa = (A < 0);
  assign sb = (B < 0);
  assign sc = (C < 0);

  always_comb begin
    ovf = 1'b0;
    if (op == CO_N'(CO_AD)) begin
      ovf = (sa == sb) && (sc != sa);
    end else if (op == CO_N'(CO_SB)) begin
      ovf = (sa != sb) && (sc != sa);
    end
  end

endmodule
`endif

// File: rtl/eval_sequencer.sv
// Evaluator reduction step: pop operator, pop B then A, run the ALU, push result.
// Define EVAL_OVF_CHECK_EN to trap signed add/sub overflow instead of wrapping.
module eval_sequencer
  import eval_sequencer_pkg::*;
#(
  parameter int CD_N = 16,
  parameter int CO_N = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   clr,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic        [CO_N-1:0] op_data,
  input  logic                   op_empty,
  output logic                   op_pop,
  input  logic signed [CD_N-1:0] dt_data,
  input  logic                   dt_empty,
  output logic                   dt_pop,
  output logic                   dt_push,
  output logic signed [CD_N-1:0] dt_wdata,
  output logic signed [CD_N-1:0] al_A,
  output logic signed [CD_N-1:0] al_B,
  output logic        [CO_N-1:0] al_op,
  output logic                   al_start,
  input  logic signed [CD_N-1:0] al_C,
  input  logic                   al_done,
  input  logic                   al_err
);

  es_state_e              state_q, state_d;
  logic        [CO_N-1:0] op_q, op_d;
  logic signed [CD_N-1:0] a_q, a_d;
  logic signed [CD_N-1:0] b_q, b_d;
  logic signed [CD_N-1:0] c_q, c_d;
  logic                   op_valid;
  logic                   ovf;

  assign op_valid = (op_data == CO_N'(CO_AD)) || (op_data == CO_N'(CO_SB)) ||
                    (op_data == CO_N'(CO_MU)) || (op_data == CO_N'(CO_DI));

`ifdef EVAL_OVF_CHECK_EN
  eval_ovf_detect #(
    .CD_N (CD_N),
    .CO_N (CO_N)
  ) u_ovf (
    .A   (a_q),
    .B   (b_q),
    .C   (al_C),
    .op  (op_q),
    .ovf (ovf)
  );
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ES_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ES_IDLE:   if (start) state_d = ES_POP_OP;
      ES_POP_OP: state_d = (op_empty || !op_valid) ? ES_ERR : ES_POP_B;
      ES_POP_B:  state_d = dt_empty ? ES_ERR : ES_POP_A;
      ES_POP_A:  state_d = dt_empty ? ES_ERR : ES_EXEC;
      ES_EXEC:   state_d = ES_WAIT;
      ES_WAIT:   if (al_done) state_d = (al_err || ovf) ? ES_ERR : ES_PUSH;
      ES_PUSH:   state_d = ES_DONE;
      ES_DONE:   state_d = ES_IDLE;
      ES_ERR:    if (clr) state_d = ES_IDLE;
      default:   state_d = ES_IDLE;
    endcase
  end

  // Pops are the only outputs gated by an input: an empty stack must never be popped.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    op_pop   = 1'b0;
    dt_pop   = 1'b0;
    dt_push  = 1'b0;
    al_start = 1'b0;
    case (state_q)
      ES_POP_OP: begin busy = 1'b1; op_pop = !op_empty; end
      ES_POP_B:  begin busy = 1'b1; dt_pop = !dt_empty; end
      ES_POP_A:  begin busy = 1'b1; dt_pop = !dt_empty; end
      ES_EXEC:   begin busy = 1'b1; al_start = 1'b1; end
      ES_WAIT:   busy = 1'b1;
      ES_PUSH:   begin busy = 1'b1; dt_push = 1'b1; end
      ES_DONE:   done = 1'b1;
      ES_ERR:    err = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    c_d  = c_q;
    case (state_q)
      ES_POP_OP: if (!op_empty) op_d = op_data;
      ES_POP_B:  if (!dt_empty) b_d = dt_data;
      ES_POP_A:  if (!dt_empty) a_d = dt_data;
      ES_WAIT:   if (al_done && !al_err && !ovf) c_d = al_C;
      default:   ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
    end else begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
    end
  end

  assign al_A     = a_q;
  assign al_B     = b_q;
  assign al_op    = op_q;
  assign dt_wdata = c_q;

endmodule

// File: tb/tb_eval_sequencer.sv
// Self-checking bench for eval_sequencer: stack/ALU environment plus a step-level reference model.
`timescale 1ns/1ps
module tb_eval_sequencer;
  import eval_sequencer_pkg::*;

  localparam int CD_N = 16;
  localparam int CO_N = 4;

  logic Clock = 1'b0;
  logic Reset, start, clr;
  logic busy, done, err;
  logic [CO_N-1:0] op_data, al_op;
  logic op_empty, op_pop, dt_empty, dt_pop, dt_push, al_start, al_done, al_err;
  logic signed [CD_N-1:0] dt_data, dt_wdata, al_A, al_B, al_C;

  eval_sequencer #(.CD_N(CD_N), .CO_N(CO_N)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .clr(clr),
    .busy(busy), .done(done), .err(err),
    .op_data(op_data), .op_empty(op_empty), .op_pop(op_pop),
    .dt_data(dt_data), .dt_empty(dt_empty), .dt_pop(dt_pop), .dt_push(dt_push),
    .dt_wdata(dt_wdata), .al_A(al_A), .al_B(al_B), .al_op(al_op), .al_start(al_start),
    .al_C(al_C), .al_done(al_done), .al_err(al_err)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  logic [CO_N-1:0]        op_stk[$];
  logic signed [CD_N-1:0] dt_stk[$];

  int cyc, poke_cyc, spur_cyc, alu_lat, alu_cnt;
  logic signed [CD_N-1:0] alu_res;
  logic alu_e;
  int n_op_pop, n_dt_pop, n_push, n_alstart, cyc_alstart, cyc_push, cyc_done, cyc_err;
  logic signed [CD_N-1:0] push_val, seen_A, seen_B;
  logic [CO_N-1:0] seen_op;
  logic busy1, s_busy, s_err;
  logic [63:0] snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    op_empty = (op_stk.size() == 0);
    op_data  = op_empty ? CO_N'($urandom) : op_stk[$];
    dt_empty = (dt_stk.size() == 0);
    dt_data  = dt_empty ? CD_N'($urandom) : dt_stk[$];
  endtask

  task automatic alu_model(input logic signed [CD_N-1:0] a, input logic signed [CD_N-1:0] b,
                           input logic [CO_N-1:0] op);
    alu_e = 1'b0;
    case (op)
      CO_AD: alu_res = a + b;
      CO_SB: alu_res = a - b;
      CO_MU: alu_res = a * b;
      CO_DI: if (b == 0) begin alu_e = 1'b1; alu_res = '0; end else alu_res = a / b;
      default: begin alu_e = 1'b1; alu_res = '0; end
    endcase
  endtask

  // One clock: observe outputs mid-cycle, then apply stack and ALU effects after the edge.
  task automatic tick();
    logic p_op, p_dt, p_push;
    logic signed [CD_N-1:0] w;
    @(negedge Clock);
    snap   = {busy, done, err, op_pop, dt_pop, dt_push, al_start, dt_wdata, al_A, al_B, al_op};
    s_busy = busy;
    s_err  = err;
    p_op = op_pop; p_dt = dt_pop; p_push = dt_push; w = dt_wdata;
    if (op_pop) n_op_pop++;
    if (dt_pop) n_dt_pop++;
    if (dt_push) begin n_push++; cyc_push = cyc; push_val = dt_wdata; end
    if (al_start) begin
      n_alstart++; cyc_alstart = cyc;
      seen_A = al_A; seen_B = al_B; seen_op = al_op;
      alu_cnt = alu_lat;
      alu_model(al_A, al_B, al_op);
    end
    if (done && cyc_done < 0) cyc_done = cyc;
    if (err && cyc_err < 0) cyc_err = cyc;
    if (cyc == 1) busy1 = busy;
    @(posedge Clock); #1;
    if (p_op) void'(op_stk.pop_back());
    if (p_dt) void'(dt_stk.pop_back());
    if (p_push) dt_stk.push_back(w);
    refresh();
    cyc++;
    if (poke_cyc > 0) start = (cyc == poke_cyc);
    al_done = 1'b0;
    al_err  = 1'($urandom);
    al_C    = CD_N'($urandom);
    if (cyc == spur_cyc) begin al_done = 1'b1; al_err = 1'b1; end
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin al_done = 1'b1; al_C = alu_res; al_err = alu_e; end
    end
  endtask

  task automatic clear_counts();
    n_op_pop = 0; n_dt_pop = 0; n_push = 0; n_alstart = 0;
    cyc_alstart = -1; cyc_push = -1; cyc_done = -1; cyc_err = -1;
    busy1 = 1'b0; alu_cnt = 0;
  endtask

  task automatic do_step(input string tag, input int lat, input int poke, input bit spur);
    logic signed [CD_N-1:0] exp_dt[$];
    logic [CO_N-1:0]        exp_op[$];
    int e_oppop = 0, e_dtpop = 0, e_errcyc = -1, e_done = -1, full = 0;
    int lim = 1 << (CD_N - 1);
    bit same;
    logic signed [CD_N-1:0] eA = '0, eB = '0, eC = '0;
    logic [CO_N-1:0] eop = '0;
    exp_dt = dt_stk;
    exp_op = op_stk;
    if (exp_op.size() == 0) e_errcyc = 2;
    else begin
      eop = exp_op.pop_back(); e_oppop = 1;
      if (!(eop inside {CO_AD, CO_SB, CO_MU, CO_DI})) e_errcyc = 2;
      else if (exp_dt.size() == 0) e_errcyc = 3;
      else begin
        eB = exp_dt.pop_back(); e_dtpop = 1;
        if (exp_dt.size() == 0) e_errcyc = 4;
        else begin
          eA = exp_dt.pop_back(); e_dtpop = 2;
          case (eop)
            CO_AD:   full = int'(eA) + int'(eB);
            CO_SB:   full = int'(eA) - int'(eB);
            CO_MU:   full = int'(eA) * int'(eB);
            default: full = (eB == 0) ? 0 : int'(eA) / int'(eB);
          endcase
          eC = CD_N'(full);
          if (eop == CO_DI && eB == 0) e_errcyc = 5 + lat;
`ifdef EVAL_OVF_CHECK_EN
          else if ((eop == CO_AD || eop == CO_SB) && (full >= lim || full < -lim)) e_errcyc = 5 + lat;
`endif
          else begin exp_dt.push_back(eC); e_done = 6 + lat; end
        end
      end
    end

    clear_counts();
    alu_lat = lat; poke_cyc = poke; spur_cyc = spur ? 4 : 0;
    refresh();
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0; cyc = 1;
    while (cyc_done < 0 && cyc_err < 0 && cyc < 60) tick();
    poke_cyc = 0;

    chk({tag, ":busy"}, busy1, 1'b1);
    chk({tag, ":op_pops"}, n_op_pop, e_oppop);
    chk({tag, ":dt_pops"}, n_dt_pop, e_dtpop);
    chk({tag, ":err_cyc"}, cyc_err, e_errcyc);
    chk({tag, ":done_cyc"}, cyc_done, e_done);
    if (e_dtpop == 2) begin
      chk({tag, ":al_A"}, seen_A, eA);
      chk({tag, ":al_B"}, seen_B, eB);
      chk({tag, ":al_op"}, seen_op, eop);
      chk({tag, ":al_start_cyc"}, cyc_alstart, 4);
      chk({tag, ":al_start_cnt"}, n_alstart, 1);
    end
    if (e_done > 0) begin
      chk({tag, ":push_val"}, push_val, eC);
      chk({tag, ":push_cyc"}, cyc_push, 5 + lat);
    end
    chk({tag, ":push_cnt"}, n_push, (e_done > 0) ? 1 : 0);
    same = (dt_stk.size() == exp_dt.size());
    if (same) for (int i = 0; i < exp_dt.size(); i++) if (dt_stk[i] !== exp_dt[i]) same = 1'b0;
    chk({tag, ":dt_stack"}, same, 1'b1);

    if (e_errcyc > 0) begin
      start = 1'b1; tick(); start = 1'b0;
      clr = 1'b1; tick(); clr = 1'b0;
      chk({tag, ":err_held"}, s_err, 1'b1);
      chk({tag, ":err_no_pop"}, n_op_pop, e_oppop);
      tick();
      chk({tag, ":err_clr"}, {s_err, s_busy}, 2'b00);
    end
  endtask

  function automatic logic signed [CD_N-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 16'sh7FFF;
      1: return 16'sh8000;
      2: return 16'sd0;
      3: return -16'sd1;
      default: return CD_N'($urandom);
    endcase
  endfunction

  initial begin
    Reset = 1'b0; start = 1'b0; clr = 1'b0;
    al_done = 1'b0; al_err = 1'b0; al_C = '0;
    cyc = 0; poke_cyc = 0; spur_cyc = 0; alu_lat = 1;
    op_stk.delete(); dt_stk.delete();
    refresh();
    clear_counts();
    repeat (2) tick();
    chk("reset:outputs", snap, 64'd0);
    Reset = 1'b1;
    tick();

    op_stk = {CO_SB}; dt_stk = {16'sd11, 16'sd7, 16'sd3};
    do_step("sub_7_3", 1, 0, 1'b1);

    op_stk = {CO_DI}; dt_stk = {16'sd5, 16'sd0};
    do_step("div_zero", 2, 0, 1'b0);

    op_stk = {CO_AD}; dt_stk = {16'sd42};
    do_step("one_operand", 1, 0, 1'b0);

    op_stk = {CO_AD}; dt_stk = {16'sh7FFF, 16'sd1};
    do_step("add_ovf", 2, 0, 1'b0);

    op_stk = {CO_MU}; dt_stk = {-16'sd3, 16'sd7};
    do_step("start_in_wait", 5, 6, 1'b0);

    op_stk = {}; dt_stk = {16'sd1, 16'sd2};
    do_step("op_empty", 1, 0, 1'b0);

    op_stk = {4'hF}; dt_stk = {16'sd1, 16'sd2};
    do_step("bad_op", 1, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int k, depth;
      op_stk.delete(); dt_stk.delete();
      k = $urandom_range(0, 9);
      if (k == 1) op_stk.push_back(($urandom_range(0, 1) == 0) ? 4'h0 : 4'hC);
      else if (k != 0) begin
        case ($urandom_range(0, 3))
          0: op_stk.push_back(CO_AD);
          1: op_stk.push_back(CO_SB);
          2: op_stk.push_back(CO_MU);
          default: op_stk.push_back(CO_DI);
        endcase
      end
      depth = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 3);
      for (int j = 0; j < depth; j++) dt_stk.push_back(rnd_val());
      do_step("rnd", $urandom_range(1, 4), 0, 1'($urandom));
    end

    // Reset while the ALU is busy: nothing may follow, not even the late completion.
    op_stk = {CO_AD}; dt_stk = {16'sd5, 16'sd9};
    clear_counts();
    alu_lat = 6; poke_cyc = 0; spur_cyc = 0;
    refresh();
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0; cyc = 1;
    while (cyc < 6) tick();
    Reset = 1'b0; tick(); Reset = 1'b1; tick();
    chk("rst_wait:outputs", snap, 64'd0);
    repeat (10) tick();
    chk("rst_wait:no_push", n_push, 0);
    chk("rst_wait:no_done", cyc_done, -1);
    chk("rst_wait:idle", {s_busy, s_err}, 2'b00);
    chk("rst_wait:al_start_cnt", n_alstart, 1);
    chk("rst_wait:dt_left", dt_stk.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
